// File: rtl/dpd_train_seq.sv
// dpd_train_seq: sequencer for one DPD training run.
// It triggers the training-signal player and waits out the player latency
// plus the PA feedback delay. It then captures N_SAMP feedback samples per
// burst, repeats for averaging, and hands the buffer to the coefficient
// estimator through a start/done handshake.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, iters,         run request; burst count (0 means 1) and feedback
//   fb_delay            delay, both latched when req is accepted in IDLE
//   abort               cancel the run from any non-IDLE state
//   play_start          one-cycle player start pulse
//   cap_en, cap_addr    capture-buffer write enable and sample index
//   cap_first           burst 0 marker (overwrite rather than accumulate)
//   est_start/est_done  estimator handshake
//   busy, done, err     status: running, success pulse, sticky timeout
module dpd_train_seq #(
    parameter int unsigned N_SAMP   = 1024,
    parameter int unsigned AW       = 10,
    parameter int unsigned PLAY_LAT = 4,
    parameter int unsigned GAP      = 4,
    parameter int unsigned TO_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [3:0]    iters,
    input  logic [7:0]    fb_delay,
    input  logic          abort,
    output logic          play_start,
    output logic          cap_en,
    output logic [AW-1:0] cap_addr,
    output logic          cap_first,
    output logic          est_start,
    input  logic          est_done,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned CW = 9;
    localparam int unsigned BW = 4;
    // Last timeout count before the counter would reach all-ones.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT, S_CAPT, S_GAP, S_EST, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [BW-1:0]   iters_q, iters_d;
    logic [7:0]      fbd_q, fbd_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   lat_m1;
    logic            play_start_q, play_start_d;
    logic            cap_en_q, cap_en_d;
    logic            cap_first_q, cap_first_d;
    logic            est_start_q, est_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        iters_d  = iters_q;
        fbd_d    = fbd_q;
        to_d     = to_q;
        err_d    = err_q;
        lat_m1   = CW'(PLAY_LAT) + CW'(fbd_q) - CW'(1);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    iters_d = (iters == '0) ? BW'(1) : iters;
                    fbd_d   = fb_delay;
                    err_d   = 1'b0;
                    burst_d = '0;
                    state_d = S_ARM;
                end
            end
            // The ARM cycle already counts toward the latency, so the
            // counter hits 0 in the last WAIT cycle before capture.
            S_ARM: begin
                if (lat_m1 == '0) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d   = lat_m1 - CW'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_CAPT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CAPT: begin
                if (addr_q == AW'(N_SAMP - 1)) begin
                    burst_d = burst_q + BW'(1);
                    if (burst_d == iters_q) begin
                        to_d    = '0;
                        state_d = S_EST;
                    end else begin
                        // GAP idle cycles plus one so the player sees start low.
                        cnt_d   = CW'(GAP);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_ARM;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_EST: begin
                if (est_done) begin
                    state_d = S_FIN;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

        addr_d       = ((state_q == S_CAPT) && (state_d == S_CAPT)) ? addr_q + AW'(1) : '0;
        play_start_d = (state_d == S_ARM);
        cap_en_d     = (state_d == S_CAPT);
        cap_first_d  = (state_d == S_CAPT) && (burst_q == '0);
        est_start_d  = (state_d == S_EST) && (state_q != S_EST);
        done_d       = (state_d == S_FIN);
        // busy drops together with the done pulse.
        busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            burst_q      <= '0;
            iters_q      <= '0;
            fbd_q        <= '0;
            to_q         <= '0;
            addr_q       <= '0;
            play_start_q <= 1'b0;
            cap_en_q     <= 1'b0;
            cap_first_q  <= 1'b0;
            est_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            burst_q      <= burst_d;
            iters_q      <= iters_d;
            fbd_q        <= fbd_d;
            to_q         <= to_d;
            addr_q       <= addr_d;
            play_start_q <= play_start_d;
            cap_en_q     <= cap_en_d;
            cap_first_q  <= cap_first_d;
            est_start_q  <= est_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign play_start = play_start_q;
    assign cap_en     = cap_en_q;
    assign cap_addr   = addr_q;
    assign cap_first  = cap_first_q;
    assign est_start  = est_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dpd_train_seq.sv
// Testbench for dpd_train_seq: table of full training runs plus directed
// abort, estimator-timeout and mid-capture reset sequences.
module tb_dpd_train_seq;

    localparam int unsigned AW = 10;

    logic          clk;
    logic          reset;
    logic          req;
    logic [3:0]    iters;
    logic [7:0]    fb_delay;
    logic          abort;
    logic          play_start;
    logic          cap_en;
    logic [AW-1:0] cap_addr;
    logic          cap_first;
    logic          est_start;
    logic          est_done;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    dpd_train_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .iters      (iters),
        .fb_delay   (fb_delay),
        .abort      (abort),
        .play_start (play_start),
        .cap_en     (cap_en),
        .cap_addr   (cap_addr),
        .cap_first  (cap_first),
        .est_start  (est_start),
        .est_done   (est_done),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int iters;
        int fb;
        int lat;        // estimator latency from est_start to est_done
        bit noise;      // inject ignored req/est_done pulses and input changes
        int exp_ps;
        int exp_capn;
        int exp_off;    // play_start to first cap_en
        int exp_period; // play_start spacing
        int exp_total;  // req cycle through done cycle inclusive
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({play_start, cap_en, cap_first, est_start, busy, done, err, cap_addr});
    endfunction

    // One complete run from IDLE, req issued in the current cycle.
    task automatic do_run(input vec_t v, input string tag);
        int c0, ps_n, ps_last, per_bad, first_ps, first_cap, cap_n, first_n;
        int addr_bad, exp_addr, last_cap, est_n, est_cyc, est_done_cyc;
        int done_n, done_cyc, busy_at_done;
        bit prev_cap, fin;
        c0 = cyc; ps_n = 0; ps_last = 0; per_bad = 0; first_ps = -1; first_cap = -1;
        cap_n = 0; first_n = 0; addr_bad = 0; exp_addr = 0; last_cap = -1;
        est_n = 0; est_cyc = -1; est_done_cyc = -100; done_n = 0; done_cyc = -1;
        busy_at_done = 1; prev_cap = 1'b0; fin = 1'b0;
        req = 1'b1; iters = 4'(v.iters); fb_delay = 8'(v.fb);
        for (int k = 0; k < 20000 && !fin; k++) begin
            step();
            req = 1'b0;
            est_done = 1'b0;
            if (play_start) begin
                if (ps_n == 0) first_ps = cyc;
                else if (cyc - ps_last != v.exp_period) per_bad++;
                ps_last = cyc;
                ps_n++;
            end
            if (cap_en) begin
                if (!prev_cap) exp_addr = 0;
                if (first_cap < 0) first_cap = cyc;
                if (int'(cap_addr) != exp_addr) addr_bad++;
                exp_addr++;
                cap_n++;
                if (cap_first) first_n++;
                last_cap = cyc;
            end
            prev_cap = cap_en;
            if (est_start) begin est_n++; est_cyc = cyc; end
            if (done) begin
                done_n++; done_cyc = cyc; busy_at_done = int'(busy); fin = 1'b1;
            end
            if (est_cyc >= 0 && cyc == est_cyc + v.lat) begin
                est_done = 1'b1;
                est_done_cyc = cyc;
            end
            if (v.noise) begin
                if (k == 0) begin iters = 4'd15; fb_delay = 8'd1; end
                if (k == 2) est_done = 1'b1;
                if (cap_n == 100 && cap_en) req = 1'b1;
            end
        end
        est_done = 1'b0;
        req = 1'b0;
        check({tag, " run finished"}, int'(fin), 1);
        check({tag, " play_start count"}, ps_n, v.exp_ps);
        check({tag, " req to play_start"}, first_ps - c0, 1);
        check({tag, " burst spacing errors"}, per_bad, 0);
        check({tag, " cap_en count"}, cap_n, v.exp_capn);
        check({tag, " cap_first count"}, first_n, 1024);
        check({tag, " cap_addr errors"}, addr_bad, 0);
        check({tag, " play_start to cap_en"}, first_cap - first_ps, v.exp_off);
        check({tag, " est_start count"}, est_n, 1);
        check({tag, " last cap_en to est_start"}, est_cyc - last_cap, 1);
        check({tag, " done count"}, done_n, 1);
        check({tag, " est_done to done"}, done_cyc - est_done_cyc, 1);
        check({tag, " busy with done"}, busy_at_done, 0);
        check({tag, " total cycles"}, done_cyc - c0 + 1, v.exp_total);
        step();
        check({tag, " idle after done"}, int'({busy, done}), 0);
    endtask

    vec_t vecs[4];

    initial begin
        bit found;
        int ps_n, e, done_n, bad;
        vec_t rv;

        vecs[0] = '{iters: 1, fb: 0,   lat: 6, noise: 1'b0, exp_ps: 1, exp_capn: 1024,
                    exp_off: 4,   exp_period: 0,    exp_total: 1037};
        vecs[1] = '{iters: 3, fb: 20,  lat: 0, noise: 1'b1, exp_ps: 3, exp_capn: 3072,
                    exp_off: 24,  exp_period: 1053, exp_total: 3157};
        vecs[2] = '{iters: 0, fb: 5,   lat: 2, noise: 1'b0, exp_ps: 1, exp_capn: 1024,
                    exp_off: 9,   exp_period: 0,    exp_total: 1038};
        vecs[3] = '{iters: 2, fb: 255, lat: 1, noise: 1'b1, exp_ps: 2, exp_capn: 2048,
                    exp_off: 259, exp_period: 1288, exp_total: 2575};
        rv      = '{iters: 1, fb: 0,   lat: 0, noise: 1'b0, exp_ps: 1, exp_capn: 1024,
                    exp_off: 4,   exp_period: 0,    exp_total: 1031};

        reset = 1'b1; req = 1'b0; iters = '0; fb_delay = '0; abort = 1'b0; est_done = 1'b0;
        step(); step(); step();
        check("reset outputs", outs(), 0);
        reset = 1'b0;
        while (cyc < 10) step();
        check("idle outputs", outs(), 0);

        // First row starts with req in cycle 10.
        for (int i = 0; i < 4; i++) begin
            do_run(vecs[i], $sformatf("row%0d", i));
            step();
        end

        // Abort at cap_addr 500 of the second burst.
        req = 1'b1; iters = 4'd2; fb_delay = 8'd0;
        found = 1'b0; ps_n = 0;
        for (int k = 0; k < 4000 && !found; k++) begin
            step();
            req = 1'b0;
            if (play_start) ps_n++;
            if (ps_n == 2 && cap_en && cap_addr == 10'd500) found = 1'b1;
        end
        check("abort point reached", int'(found), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort outputs", outs(), 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (est_start || done || busy || play_start || cap_en) bad++;
        end
        check("activity after abort", bad, 0);
        do_run(rv, "restart");

        // Estimator never answers.
        step();
        req = 1'b1; iters = 4'd1; fb_delay = 8'd0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            step();
            req = 1'b0;
            if (est_start) found = 1'b1;
        end
        check("timeout est_start seen", int'(found), 1);
        e = cyc;
        done_n = 0;
        while (cyc < e + 65534) begin
            step();
            if (done) done_n++;
        end
        check("pre-timeout err/busy", int'({err, busy}), 1);
        step();
        if (done) done_n++;
        check("timeout err/busy", int'({err, busy}), 2);
        step(); step();
        if (done) done_n++;
        check("timeout no done", done_n, 0);
        check("err sticky", int'(err), 1);
        req = 1'b1;
        step();
        req = 1'b0;
        check("req clears err", int'({err, busy, play_start}), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort after req", int'({err, busy}), 0);

        // Reset asserted mid-capture.
        step();
        req = 1'b1; iters = 4'd1; fb_delay = 8'd3;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            step();
            req = 1'b0;
            if (cap_en && cap_addr == 10'd100) found = 1'b1;
        end
        check("reset point reached", int'(found), 1);
        reset = 1'b1;
        est_done = 1'b1;
        step();
        reset = 1'b0;
        est_done = 1'b0;
        check("mid-run reset outputs", outs(), 0);
        step();
        check("post-reset idle", outs(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
